vga_timing_gen: RTL and testbench

Raster timing generator for the 1024x768 at 65 MHz video path. It sits directly upstream of the pixel colour stage.
- Produces the free-running h_counter/v_counter, video_active, sync pulses and active-area coordinates that the colour stage consumes.
- Counter origin is the start of front porch. Each line and frame runs in this order: front porch, sync, back porch, active. Active pixels therefore begin at h_counter = H_FP+H_SYNCP+H_BP.

---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_wrap_counter.sv | 28 ++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 1024x768 @ 65 MHz raster constants and colour definitions for the video path.
// Imported by the timing generator and by the downstream colour stage.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE = 1024;
    localparam int unsigned H_FP     = 24;
    localparam int unsigned H_SYNCP  = 136;
    localparam int unsigned H_BP     = 160;

    localparam int unsigned V_ACTIVE = 768;
    localparam int unsigned V_FP     = 3;
    localparam int unsigned V_SYNCP  = 6;
    localparam int unsigned V_BP     = 29;

    localparam logic HS_POL = 1'b0;
    localparam logic VS_POL = 1'b0;

    localparam int unsigned H_BLANK = H_FP + H_SYNCP + H_BP;
    localparam int unsigned H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int unsigned V_BLANK = V_FP + V_SYNCP + V_BP;
    localparam int unsigned V_TOTAL = V_BLANK + V_ACTIVE;

    localparam int unsigned CNT_W = 12;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t COLOUR_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t COLOUR_WHITE = '{r: 8'hff, g: 8'hff, b: 8'hff};
    localparam rgb_t COLOUR_RED   = '{r: 8'hff, g: 8'h00, b: 8'h00};
    localparam rgb_t COLOUR_GREEN = '{r: 8'h00, g: 8'hff, b: 8'h00};
    localparam rgb_t COLOUR_BLUE  = '{r: 8'h00, g: 8'h00, b: 8'hff};

    // Half-open window test: lo <= val < hi.
    function automatic logic in_window(logic [11:0] val, logic [11:0] lo, logic [11:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// 12-bit counter that advances on en and wraps from MAX back to 0.
// clr is a synchronous clear that takes priority over en; wrap flags count == MAX.
module vga_wrap_counter #(
    parameter int unsigned MAX = 4095
) (
    input  logic        clk,
    input  logic        en,
    input  logic        clr,
    output logic [11:0] count,
    output logic        wrap
);

    localparam logic [11:0] MAX_W = 12'(MAX);

    logic [11:0] count_q;

    assign wrap  = (count_q == MAX_W);
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= wrap ? 12'd0 : count_q + 12'd1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters with registered sync, active-area
// and frame-start outputs, all decoded from next-state counter values so nothing skews.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNCP  = vga_timing_pkg::H_SYNCP,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNCP  = vga_timing_pkg::V_SYNCP,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
    parameter logic        HS_POL   = vga_timing_pkg::HS_POL,
    parameter logic        VS_POL   = vga_timing_pkg::VS_POL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [11:0] h_counter,
    output logic [11:0] v_counter,
    output logic        video_active,
    output logic        hs,
    output logic        vs,
    output logic [11:0] active_x,
    output logic [11:0] active_y,
    output logic        frame_start
);

    import vga_timing_pkg::in_window;

    // H_TOTAL and V_TOTAL must not exceed 4096 for the 12-bit counters.
    localparam int unsigned H_BLANK = H_FP + H_SYNCP + H_BP;
    localparam int unsigned H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int unsigned V_BLANK = V_FP + V_SYNCP + V_BP;
    localparam int unsigned V_TOTAL = V_BLANK + V_ACTIVE;

    localparam logic [11:0] HS_LO   = 12'(H_FP);
    localparam logic [11:0] HS_HI   = 12'(H_FP + H_SYNCP);
    localparam logic [11:0] VS_LO   = 12'(V_FP);
    localparam logic [11:0] VS_HI   = 12'(V_FP + V_SYNCP);
    localparam logic [11:0] H_BLK_W = 12'(H_BLANK);
    localparam logic [11:0] V_BLK_W = 12'(V_BLANK);

    logic        clr;
    logic        h_wrap;
    logic        v_wrap;
    logic        v_en;
    logic [11:0] h_nx;
    logic [11:0] v_nx;

    logic        hs_d, vs_d, va_d, fs_d;
    logic [11:0] ax_d, ay_d;
    logic        hs_q, vs_q, va_q, fs_q;
    logic [11:0] ax_q, ay_q;

    assign clr  = ~rst;
    assign v_en = pix_en & h_wrap;

    vga_wrap_counter #(
        .MAX(H_TOTAL - 1)
    ) u_h_cnt (
        .clk  (clk),
        .en   (pix_en),
        .clr  (clr),
        .count(h_counter),
        .wrap (h_wrap)
    );

    vga_wrap_counter #(
        .MAX(V_TOTAL - 1)
    ) u_v_cnt (
        .clk  (clk),
        .en   (v_en),
        .clr  (clr),
        .count(v_counter),
        .wrap (v_wrap)
    );

    // Mirror the counters' advance so the decode registers land with the new position.
    always_comb begin
        h_nx = h_wrap ? 12'd0 : h_counter + 12'd1;
        v_nx = v_counter;
        if (h_wrap) begin
            v_nx = v_wrap ? 12'd0 : v_counter + 12'd1;
        end

        hs_d = in_window(h_nx, HS_LO, HS_HI) ? HS_POL : ~HS_POL;
        vs_d = in_window(v_nx, VS_LO, VS_HI) ? VS_POL : ~VS_POL;
        va_d = (h_nx >= H_BLK_W) && (v_nx >= V_BLK_W);
        ax_d = '0;
        ay_d = '0;
        if (va_d) begin
            ax_d = h_nx - H_BLK_W;
            ay_d = v_nx - V_BLK_W;
        end
        fs_d = h_wrap & v_wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            va_q <= 1'b0;
            fs_q <= 1'b0;
            ax_q <= '0;
            ay_q <= '0;
        end else if (pix_en) begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            va_q <= va_d;
            fs_q <= fs_d;
            ax_q <= ax_d;
            ay_q <= ay_d;
        end
    end

    assign hs           = hs_q;
    assign vs           = vs_q;
    assign video_active = va_q;
    assign frame_start  = fs_q;
    assign active_x     = ax_q;
    assign active_y     = ay_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 1024x768 instance for the early frame, plus a shrunken
// instance to reach frame wrap; every cycle is scored against a spec-level model.
module tb_vga_timing_gen;

    typedef struct packed {
        int hact; int hfp; int hsy; int hbp;
        int vact; int vfp; int vsy; int vbp;
    } tim_t;

    typedef struct packed {
        logic [11:0] h;
        logic [11:0] v;
        logic        va;
        logic        hs;
        logic        vs;
        logic [11:0] ax;
        logic [11:0] ay;
        logic        fs;
    } exp_t;

    localparam tim_t TA = '{hact: 1024, hfp: 24, hsy: 136, hbp: 160,
                            vact: 768, vfp: 3, vsy: 6, vbp: 29};
    localparam tim_t TB = '{hact: 16, hfp: 2, hsy: 3, hbp: 4,
                            vact: 6, vfp: 1, vsy: 2, vbp: 2};

    logic        clk = 1'b0;
    logic        rst_a = 1'b0, en_a = 1'b1;
    logic        rst_b = 1'b0, en_b = 1'b1;
    logic [11:0] a_h, a_v, a_ax, a_ay, b_h, b_v, b_ax, b_ay;
    logic        a_va, a_hs, a_vs, a_fs, b_va, b_hs, b_vs, b_fs;

    int   checks = 0;
    int   errors = 0;
    exp_t m_a, m_b;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk(clk), .rst(rst_a), .pix_en(en_a),
        .h_counter(a_h), .v_counter(a_v), .video_active(a_va), .hs(a_hs), .vs(a_vs),
        .active_x(a_ax), .active_y(a_ay), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNCP(3), .H_BP(4),
        .V_ACTIVE(6), .V_FP(1), .V_SYNCP(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_s (
        .clk(clk), .rst(rst_b), .pix_en(en_b),
        .h_counter(b_h), .v_counter(b_v), .video_active(b_va), .hs(b_hs), .vs(b_vs),
        .active_x(b_ax), .active_y(b_ay), .frame_start(b_fs)
    );

    function automatic exp_t model_next(exp_t c, logic en, logic r, tim_t t);
        exp_t n;
        int   hb, ht, vb, vt, h, v;
        hb = t.hfp + t.hsy + t.hbp;
        ht = hb + t.hact;
        vb = t.vfp + t.vsy + t.vbp;
        vt = vb + t.vact;
        n  = '0;
        if (!r) begin
            n.hs = 1'b1;
            n.vs = 1'b1;
            return n;
        end
        if (!en) return c;
        h = int'(c.h) + 1;
        v = int'(c.v);
        if (h == ht) begin
            h = 0;
            v = v + 1;
            if (v == vt) begin
                v    = 0;
                n.fs = 1'b1;
            end
        end
        n.h  = 12'(h);
        n.v  = 12'(v);
        n.hs = (h >= t.hfp && h < t.hfp + t.hsy) ? 1'b0 : 1'b1;
        n.vs = (v >= t.vfp && v < t.vfp + t.vsy) ? 1'b0 : 1'b1;
        n.va = (h >= hb) && (v >= vb);
        n.ax = n.va ? 12'(h - hb) : 12'd0;
        n.ay = n.va ? 12'(v - vb) : 12'd0;
        return n;
    endfunction

    function automatic exp_t sample(bit sel);
        exp_t s;
        if (!sel) s = '{h: a_h, v: a_v, va: a_va, hs: a_hs, vs: a_vs, ax: a_ax, ay: a_ay, fs: a_fs};
        else      s = '{h: b_h, v: b_v, va: b_va, hs: b_hs, vs: b_vs, ax: b_ax, ay: b_ay, fs: b_fs};
        return s;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Push the model's prediction, clock once, then pop and score the DUT's output.
    task automatic step(bit sel, logic en, logic r);
        exp_t e, got, want;
        if (!sel) begin
            e = model_next(m_a, en, r, TA); m_a = e; en_a = en; rst_a = r;
        end else begin
            e = model_next(m_b, en, r, TB); m_b = e; en_b = en; rst_b = r;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got  = sample(sel);
        want = sb_q.pop_front();
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL sb%0d: observed h=%0d v=%0d va=%b hs=%b vs=%b ax=%0d ay=%0d fs=%b expected h=%0d v=%0d va=%b hs=%b vs=%b ax=%0d ay=%0d fs=%b",
                   sel, got.h, got.v, got.va, got.hs, got.vs, got.ax, got.ay, got.fs,
                   want.h, want.v, want.va, want.hs, want.vs, want.ax, want.ay, want.fs);
        end
    endtask

    task automatic run_to(bit sel, int h, int v);
        exp_t m;
        int   guard;
        guard = 0;
        m = sel ? m_b : m_a;
        while (!(int'(m.h) == h && int'(m.v) == v) && guard < 100000) begin
            step(sel, 1'b1, 1'b1);
            m = sel ? m_b : m_a;
            guard++;
        end
        chk("run_to_reached", {31'd0, guard < 100000}, 32'd1);
    endtask

    initial begin
        exp_t s;
        int   period;

        // Full-size instance: reset, then the opening lines of a frame.
        step(0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0);
        s = sample(0);
        chk("rst_h", s.h, 0);
        chk("rst_v", s.v, 0);
        chk("rst_hs", s.hs, 1);
        chk("rst_vs", s.vs, 1);
        chk("rst_va", s.va, 0);
        chk("rst_fs", s.fs, 0);

        step(0, 1'b1, 1'b1);
        s = sample(0);
        chk("first_h", s.h, 1);
        chk("first_fs", s.fs, 0);
        run_to(0, 23, 0);   s = sample(0); chk("hs_h23", s.hs, 1);
        step(0, 1'b1, 1'b1); s = sample(0); chk("hs_h24", s.hs, 0);
        run_to(0, 159, 0);  s = sample(0); chk("hs_h159", s.hs, 0);
        step(0, 1'b1, 1'b1); s = sample(0); chk("hs_h160", s.hs, 1);
        chk("va_line0", s.va, 0);

        run_to(0, 1343, 0);
        step(0, 1'b1, 1'b1); s = sample(0);
        chk("hwrap_h", s.h, 0);
        chk("hwrap_v", s.v, 1);
        run_to(0, 1343, 2); s = sample(0); chk("vs_v2", s.vs, 1);
        step(0, 1'b1, 1'b1); s = sample(0); chk("vs_v3", s.vs, 0);
        run_to(0, 1343, 8); s = sample(0); chk("vs_v8", s.vs, 0);
        step(0, 1'b1, 1'b1); s = sample(0); chk("vs_v9", s.vs, 1);

        run_to(0, 319, 38); s = sample(0);
        chk("va_319", s.va, 0);
        chk("ax_319", s.ax, 0);
        step(0, 1'b1, 1'b1); s = sample(0);
        chk("va_320", s.va, 1);
        chk("ax_320", s.ax, 0);
        chk("ay_320", s.ay, 0);
        step(0, 1'b1, 1'b1); s = sample(0);
        chk("ax_321", s.ax, 1);

        // Stall: everything holds, then resumes one pixel later.
        run_to(0, 500, 40);
        for (int i = 0; i < 5; i++) begin
            step(0, 1'b0, 1'b1);
            s = sample(0);
            chk("stall_h", s.h, 500);
        end
        step(0, 1'b1, 1'b1); s = sample(0);
        chk("resume_h", s.h, 501);
        chk("resume_v", s.v, 40);

        // Reset mid-frame.
        run_to(0, 700, 41);
        step(0, 1'b1, 1'b0); s = sample(0);
        chk("mrst_h", s.h, 0);
        chk("mrst_v", s.v, 0);
        chk("mrst_hs", s.hs, 1);
        chk("mrst_vs", s.vs, 1);
        chk("mrst_fs", s.fs, 0);
        step(0, 1'b1, 1'b1);
        step(0, 1'b1, 1'b1); s = sample(0);
        chk("mrst_resume", s.h, 2);
        chk("mrst_resume_fs", s.fs, 0);
        en_a = 1'b0;

        // Shrunken instance (25x11 total): frame wrap, frame_start and period.
        step(1, 1'b1, 1'b0);
        step(1, 1'b1, 1'b1);
        run_to(1, 24, 10); s = sample(1);
        chk("last_va", s.va, 1);
        chk("last_ax", s.ax, 15);
        chk("last_ay", s.ay, 5);
        step(1, 1'b1, 1'b1); s = sample(1);
        chk("wrap_h", s.h, 0);
        chk("wrap_v", s.v, 0);
        chk("wrap_fs", s.fs, 1);
        step(1, 1'b1, 1'b1); s = sample(1);
        chk("fs_drop", s.fs, 0);
        period = 1;
        while (sample(1).fs !== 1'b1 && period < 1000) begin
            step(1, 1'b1, 1'b1);
            period++;
        end
        chk("frame_period", period, 275);

        // frame_start held across a stall, cleared on the next enabled cycle.
        run_to(1, 24, 10);
        step(1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1'b0, 1'b1);
            s = sample(1);
            chk("fs_held", s.fs, 1);
        end
        step(1, 1'b1, 1'b1); s = sample(1);
        chk("fs_after_stall", s.fs, 0);
        chk("h_after_stall", s.h, 1);

        run_to(1, 12, 3);
        step(1, 1'b1, 1'b0); s = sample(1);
        chk("b_mrst_h", s.h, 0);
        chk("b_mrst_fs", s.fs, 0);
        for (int i = 0; i < 30; i++) step(1, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
